// File: rtl/sevseg_source_scheduler.sv
// Round-robin time-multiplexing scheduler for the shared 4-digit display.
// Each owner keeps the display for a fixed dwell period. A blanking gap
// separates consecutive owners. All outputs come from registers.
module sevseg_source_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int GAP_CYCLES   = 1_000_000,
  localparam int OW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int MAXC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES,
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_SRC-1:0]     REQ,
  input  logic [16*NUM_SRC-1:0]  SRC_DATA,
  input  logic [NUM_SRC-1:0]     SRC_MODE,
  input  logic                   LOCK,
  output logic [NUM_SRC-1:0]     GNT,
  output logic [OW-1:0]          OWNER,
  output logic [15:0]            DATA_OUT,
  output logic                   MODE_OUT,
  output logic                   BLANK
);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [NUM_SRC-1:0]   gnt_q, gnt_d;
  logic [15:0]          data_q, data_d;
  logic                 mode_q, mode_d;
  logic                 blank_q, blank_d;

  logic [OW-1:0]        ptr;
  logic [OW-1:0]        next_sel;
  logic [NUM_SRC-1:0]   own_mask;
  logic                 any_req;
  logic                 other_req;
  logic                 dwell_end;
  logic                 gap_end;

  // First requesting source at or after ptr, wrapping around.
  function automatic logic [OW-1:0] pick_src(input logic [NUM_SRC-1:0] req,
                                             input logic [OW-1:0]      start);
    logic [OW-1:0] sel;
    logic [OW-1:0] idx_w;
    logic          found;
    int            idx;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx   = (int'(start) + k) % NUM_SRC;
      idx_w = OW'(idx);
      if (!found && req[idx_w]) begin
        sel   = idx_w;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // 16-bit word of the selected source.
  function automatic logic [15:0] src_word(input logic [16*NUM_SRC-1:0] d,
                                           input logic [OW-1:0]         s);
    logic [15:0] w;
    w = 16'h0000;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (OW'(i) == s) w = d[16*i +: 16];
    end
    return w;
  endfunction

  function automatic logic [NUM_SRC-1:0] onehot(input logic [OW-1:0] s);
    return {{(NUM_SRC-1){1'b0}}, 1'b1} << s;
  endfunction

  assign ptr       = (owner_q == OW'(NUM_SRC - 1)) ? '0 : owner_q + 1'b1;
  assign next_sel  = pick_src(REQ, ptr);
  assign own_mask  = onehot(owner_q);
  assign any_req   = |REQ;
  assign other_req = |(REQ & ~own_mask);
  assign dwell_end = (cnt_q == CW'(DWELL_CYCLES - 1));
  assign gap_end   = (cnt_q == CW'(GAP_CYCLES - 1));

  // Next-state and registered-output logic for the IDLE/SHOW/GAP controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    mode_d  = mode_q;
    blank_d = blank_q;
    case (state_q)
      S_IDLE: begin
        gnt_d   = '0;
        blank_d = 1'b1;
        cnt_d   = '0;
        if (any_req) begin
          state_d = S_SHOW;
          owner_d = next_sel;
          gnt_d   = onehot(next_sel);
          blank_d = 1'b0;
          data_d  = src_word(SRC_DATA, next_sel);
          mode_d  = SRC_MODE[next_sel];
        end
      end
      S_SHOW: begin
        // Track live source updates every displayed cycle.
        data_d = src_word(SRC_DATA, owner_q);
        mode_d = SRC_MODE[owner_q];
        if (!REQ[owner_q]) begin
          // Release wins over lock and expiry.
          state_d = S_GAP;
          cnt_d   = '0;
          gnt_d   = '0;
          blank_d = 1'b1;
        end else if (LOCK) begin
          cnt_d = cnt_q;
        end else if (dwell_end) begin
          cnt_d = '0;
          if (other_req) begin
            state_d = S_GAP;
            gnt_d   = '0;
            blank_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (gap_end) begin
          cnt_d = '0;
          if (any_req) begin
            state_d = S_SHOW;
            owner_d = next_sel;
            gnt_d   = onehot(next_sel);
            blank_d = 1'b0;
            data_d  = src_word(SRC_DATA, next_sel);
            mode_d  = SRC_MODE[next_sel];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
        blank_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset parks owner at the last source so the first pick is source 0.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= OW'(NUM_SRC - 1);
      gnt_q   <= '0;
      data_q  <= 16'h0000;
      mode_q  <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
    end
  end

  assign GNT      = gnt_q;
  assign OWNER    = owner_q;
  assign DATA_OUT = data_q;
  assign MODE_OUT = mode_q;
  assign BLANK    = blank_q;

endmodule

// File: doc/sevseg_source_scheduler.md
# sevseg_source_scheduler

Time-multiplexing scheduler that shares the single 4-digit seven-segment display between up to NUM_SRC requesters, such as the RAT MCU output port, a debug register, or a switch readback. It grants the display round-robin, holding each owner for a fixed dwell period with a blanking gap between owners. It outputs the selected 16-bit value and hex/decimal mode, registered, to drive the display driver's DATA_IN/MODE inputs. BLANK gates the anodes off externally.

## Interface
Parameters:
- NUM_SRC, 4, number of requesters (2..8)
- DWELL_CYCLES, 100_000_000, cycles one owner holds the display (1 s at 100 MHz); ≥ 2
- GAP_CYCLES, 1_000_000, blanking cycles between owners (10 ms); ≥ 1

Ports:
- CLK  in  1  100 MHz clock; all logic on rising edge
- RST_N  in  1  reset, synchronous, active-low
- REQ  in  NUM_SRC  level request per source; bit i high = source i wants display time
- SRC_DATA  in  16*NUM_SRC  source i value at [16i+15:16i]
- SRC_MODE  in  NUM_SRC  source i mode: 0 hex, 1 decimal
- LOCK  in  1  freezes the current owner: suppresses dwell expiry
- GNT  out  NUM_SRC  one-hot grant; all-zero when no owner
- OWNER  out  $clog2(NUM_SRC)  index of current/last owner
- DATA_OUT  out  16  value to display
- MODE_OUT  out  1  mode to display
- BLANK  out  1  1 = display must be dark

## Operation
- States: IDLE, SHOW, GAP. Cycle counter CNT has width $clog2(max(DWELL_CYCLES, GAP_CYCLES)). Round-robin pointer PTR = OWNER+1 mod NUM_SRC.
- Pick function: the first i with REQ[i]=1, searching PTR, PTR+1, … with wrap-around mod NUM_SRC.
- IDLE: BLANK=1, GNT=0, CNT=0. If any REQ, go SHOW with OWNER=pick, CNT=0.
- SHOW: GNT[OWNER]=1 and BLANK=0. Each cycle DATA_OUT<=SRC_DATA[OWNER] and MODE_OUT<=SRC_MODE[OWNER], so live updates are tracked.
  - REQ[OWNER] drops: go to GAP immediately (CNT=0). This takes priority over all other SHOW rules.
  - LOCK=1: CNT holds its value and no expiry occurs.
  - Otherwise CNT increments. At CNT==DWELL_CYCLES-1:
    - If any other source requests, go to GAP.
    - Else, if REQ[OWNER] is still high, set CNT=0 and stay in SHOW (no gap, no GNT glitch).
- GAP: GNT=0, BLANK=1, DATA_OUT/MODE_OUT hold. CNT increments. At CNT==GAP_CYCLES-1 evaluate pick:
  - Request found: go SHOW with the new OWNER (may equal the old owner if it alone requests), CNT=0.
  - No request: go IDLE.
  - LOCK is ignored in GAP and IDLE.
- Requests arriving during GAP are honoured at gap end; requests that drop before gap end are lost (no memory).
- GNT is informational; sources need not wait for GNT before driving SRC_DATA.
- Reset mid-operation: any state returns to IDLE next edge; no partial dwell is retained.

## Timing
- Reset values (RST_N=0 sampled at edge): state IDLE, CNT=0, OWNER=NUM_SRC-1 (so the first pick starts at source 0), GNT=0, DATA_OUT=16'h0000, MODE_OUT=0, BLANK=1.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE→SHOW: REQ sampled high at edge N gives GNT/BLANK=0 after edge N. DATA_OUT from SRC_DATA sampled at edge N is also valid after edge N.
- SRC_DATA→DATA_OUT latency: 1 cycle while in SHOW.
- Full dwell: exactly DWELL_CYCLES cycles with GNT high, then exactly GAP_CYCLES cycles with BLANK=1, then the next owner's GNT.
- Early release: REQ[OWNER] low sampled at edge N gives GNT=0 and BLANK=1 after edge N.
- Simultaneous: if REQ[OWNER] drops on the same edge as dwell expiry, take the release path (identical outcome: GAP).

## Test plan
Run with NUM_SRC=4, DWELL_CYCLES=8, GAP_CYCLES=2.
- Reset, then REQ=4'b0000 for 20 cycles → GNT=0, BLANK=1, DATA_OUT=0, OWNER=3 throughout.
- REQ=4'b0101, SRC_DATA0=16'h1234, SRC_DATA2=16'hBEEF → GNT=0001 for 8 cycles with DATA_OUT=1234; BLANK for 2; GNT=0100 for 8 with DATA_OUT=BEEF; then back to 0001.
- Only REQ[1] held for 30 cycles; change SRC_DATA1 from 16'h0042 to 16'h0099 at cycle 5 → GNT=0010 continuous with no gap; DATA_OUT=0099 one cycle after the change.
- REQ=4'b1001, source 0 owner; drop REQ[0] at cycle 3 → GNT=0 next cycle, 2 blank cycles, then GNT=1000.
- LOCK=1 during source 0 SHOW with REQ=4'b0011 for 50 cycles → GNT stays 0001; deassert LOCK → expiry after the remaining dwell count, then GAP, then GNT=0010.
- Pulse RST_N low for 1 cycle mid-SHOW → next cycle all outputs at reset values; with requests still pending, GNT=0001 (source 0 first) one cycle after release.
